// File: rtl/rv32i_mem_stage_pkg.sv
// Shared opcode/funct3 encodings and memory-op legality check for the MEM stage.
package rv32i_mem_stage_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when a load/store cannot be issued: unknown width encoding or
  // an address not aligned to the access size.
  function automatic logic mem_op_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (is_store) illegal = (funct3 >= 3'b011);
    else          illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/rv32i_mem_stage_load_align.sv
// Selects the addressed byte/half from a raw read word and extends it.
module rv32i_load_align
  import rv32i_mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension by funct3.
  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32 memory-access stage: runs req/ack data-memory transactions, stalls
// upstream while one is outstanding, and registers the MEM/WB fields.
module rv32i_mem_stage
  import rv32i_mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic [4:0]       i_rd,
  input  logic             i_reg_write,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [WIDTH-1:0] o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_valid,
  output logic [6:0]       o_opcode,
  output logic [WIDTH-1:0] o_alu_result,
  output logic [WIDTH-1:0] o_mem_data,
  output logic [4:0]       o_rd,
  output logic             o_reg_write,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_fault
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e state_q, state_d;

  logic             is_load, is_store, fault, accept, start_mem, done;
  logic             rw_in;
  logic [3:0]       be_d;
  logic [WIDTH-1:0] wdata_d;
  logic [WIDTH-1:0] aligned;

  // Captured transaction (held stable through ACCESS).
  logic [WIDTH-1:0] addr_q, wdata_q, pc_q;
  logic [3:0]       be_q;
  logic [2:0]       f3_q;
  logic [6:0]       op_q;
  logic [4:0]       rd_q;
  logic             we_q, rw_q;

  // MEM/WB output registers.
  logic             wb_valid_q, wb_fault_q, wb_rw_q;
  logic [6:0]       wb_op_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_alu_q, wb_mem_q, wb_pc_q;

  assign is_load   = (i_opcode == OPCODE_LOAD);
  assign is_store  = (i_opcode == OPCODE_STORE);
  assign fault     = (is_load || is_store) &&
                     mem_op_fault(is_store, i_funct3, i_alu_result[1:0]);
  assign accept    = i_valid && o_ready;
  assign start_mem = accept && (is_load || is_store) && !fault;
  assign done      = (state_q == S_ACCESS) && i_dmem_ack;
  assign rw_in     = i_reg_write && (i_rd != 5'd0) && !is_store && !fault;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: enter ACCESS on a legal memory op, leave on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_mem)  state_d = S_ACCESS;
      S_ACCESS: if (i_dmem_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall upstream and request memory while in ACCESS.
  always_comb begin
    o_ready    = (state_q == S_IDLE);
    o_dmem_req = (state_q == S_ACCESS);
  end

  // Store lane enables and replicated write data.
  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    if (is_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << i_alu_result[1:0];
          wdata_d = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          be_d    = i_alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{i_store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = i_store_data;
        end
      endcase
    end
  end

  // Capture the memory transaction on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else if (start_mem) begin
      addr_q  <= i_alu_result;
      wdata_q <= wdata_d;
      pc_q    <= i_pc;
      be_q    <= be_d;
      f3_q    <= i_funct3;
      op_q    <= i_opcode;
      rd_q    <= i_rd;
      we_q    <= is_store;
      rw_q    <= rw_in;
    end
  end

  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;

  rv32i_load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata_i   (i_dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (aligned)
  );

  // MEM/WB register: non-memory and faulting ops retire one cycle after
  // acceptance; memory ops retire on the ack edge from the captured fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_valid_q <= 1'b0;
      wb_fault_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_op_q    <= '0;
      wb_rd_q    <= '0;
      wb_alu_q   <= '0;
      wb_mem_q   <= '0;
      wb_pc_q    <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_fault_q <= 1'b0;
      if (accept && !start_mem) begin
        wb_valid_q <= 1'b1;
        wb_fault_q <= fault;
        wb_rw_q    <= rw_in;
        wb_op_q    <= i_opcode;
        wb_rd_q    <= i_rd;
        wb_alu_q   <= i_alu_result;
        wb_mem_q   <= '0;
        wb_pc_q    <= i_pc;
      end else if (done) begin
        wb_valid_q <= 1'b1;
        wb_rw_q    <= rw_q;
        wb_op_q    <= op_q;
        wb_rd_q    <= rd_q;
        wb_alu_q   <= addr_q;
        wb_mem_q   <= we_q ? '0 : aligned;
        wb_pc_q    <= pc_q;
      end
    end
  end

  assign o_valid      = wb_valid_q;
  assign o_fault      = wb_fault_q;
  assign o_reg_write  = wb_rw_q;
  assign o_opcode     = wb_op_q;
  assign o_rd         = wb_rd_q;
  assign o_alu_result = wb_alu_q;
  assign o_mem_data   = wb_mem_q;
  assign o_pc         = wb_pc_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Scoreboard bench for rv32i_mem_stage: stimulus pushes expected MEM/WB
// records, a negedge monitor pops and compares on every o_valid.
module tb_rv32i_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

  logic        clk, rst;
  logic        i_valid, o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result, i_store_data, i_pc;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [6:0]  o_opcode;
  logic [31:0] o_alu_result, o_mem_data, o_pc;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_fault;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pc;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  rv32i_mem_stage #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .i_pc(i_pc), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid), .o_opcode(o_opcode),
    .o_alu_result(o_alu_result), .o_mem_data(o_mem_data), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_pc(o_pc), .o_fault(o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no retirement (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_opcode",    32'(o_opcode),    32'(mon_e.op));
        chk("wb_alu",       o_alu_result,     mon_e.alu);
        chk("wb_mem_data",  o_mem_data,       mon_e.mem);
        chk("wb_rd",        32'(o_rd),        32'(mon_e.rd));
        chk("wb_reg_write", 32'(o_reg_write), 32'(mon_e.rw));
        chk("wb_pc",        o_pc,             32'(mon_e.pc));
        chk("wb_fault",     32'(o_fault),     32'(mon_e.flt));
      end
    end else begin
      chk("fault_idle", 32'(o_fault), 32'd0);
    end
  end

  task automatic set_idle();
    i_valid = 1'b0;
    i_opcode = '0; i_funct3 = '0; i_alu_result = '0; i_store_data = '0;
    i_rd = '0; i_reg_write = 1'b0; i_pc = '0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc);
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_alu_result = alu;
    i_store_data = sd; i_rd = rd; i_reg_write = rw; i_pc = pc;
  endtask

  task automatic push(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] rd, input logic rw, input logic [31:0] pc,
                      input logic flt);
    exp_t e;
    e.op = op; e.alu = alu; e.mem = mem; e.rd = rd; e.rw = rw; e.pc = pc; e.flt = flt;
    sb.push_back(e);
  endtask

  // Present one instruction for a single cycle; stage must be ready.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc);
    @(posedge clk); #1;
    drive(op, f3, alu, sd, rd, rw, pc);
    @(negedge clk);
    chk("ready_at_issue", 32'(o_ready), 32'd1);
  endtask

  // Act as memory: hold off k cycles, checking the request stays stable,
  // then ack in the k-th ACCESS cycle.
  task automatic mem_access(input int k, input logic [31:0] exp_addr, input logic exp_we,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] rdata);
    @(posedge clk); #1;
    set_idle();
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      chk("req_held",   32'(o_dmem_req), 32'd1);
      chk("stall",      32'(o_ready),    32'd0);
      chk("dmem_addr",  o_dmem_addr,     exp_addr);
      chk("dmem_we",    32'(o_dmem_we),  32'(exp_we));
      if (exp_we) begin
        chk("dmem_be",    32'(o_dmem_be), 32'(exp_be));
        chk("dmem_wdata", o_dmem_wdata,   exp_wdata);
      end
      if (i == k) begin
        i_dmem_ack = 1'b1;
        i_dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      i_dmem_ack = 1'b0;
      i_dmem_rdata = JUNK;
    end
    @(negedge clk);
    chk("req_dropped", 32'(o_dmem_req), 32'd0);
    chk("ready_back",  32'(o_ready),    32'd1);
  endtask

  // Memory op that must fault: no request, stage stays ready.
  task automatic fault_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [31:0] pc);
    issue(op, f3, alu, 32'h5555_5555, rd, 1'b1, pc);
    push(op, alu, 32'd0, rd, 1'b0, pc, 1'b1);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    chk("fault_no_req", 32'(o_dmem_req), 32'd0);
    chk("fault_ready",  32'(o_ready),    32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = JUNK;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid),    32'd0);
    chk("rst_req",   32'(o_dmem_req), 32'd0);
    chk("rst_alu",   o_alu_result,    32'd0);
    chk("rst_addr",  o_dmem_addr,     32'd0);
    chk("rst_ready", 32'(o_ready),    32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADDI x3 = 5
    issue(OP_IMM, 3'b000, 32'h0000_0005, 32'd0, 5'd3, 1'b1, 32'h100);
    push(OP_IMM, 32'h5, 32'd0, 5'd3, 1'b1, 32'h100, 1'b0);
    @(posedge clk); #1; set_idle();
    @(negedge clk);
    chk("addi_ready", 32'(o_ready), 32'd1);

    // LB / LBU at byte 3, rdata 0x80AA_BBCC, 3 ACCESS cycles
    issue(OP_LOAD, 3'b000, 32'h1003, 32'd0, 5'd5, 1'b1, 32'h104);
    push(OP_LOAD, 32'h1003, 32'hFFFF_FF80, 5'd5, 1'b1, 32'h104, 1'b0);
    mem_access(3, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80AA_BBCC);
    issue(OP_LOAD, 3'b100, 32'h1003, 32'd0, 5'd6, 1'b1, 32'h108);
    push(OP_LOAD, 32'h1003, 32'h0000_0080, 5'd6, 1'b1, 32'h108, 1'b0);
    mem_access(3, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80AA_BBCC);

    // LH upper half, LHU lower half, LW to x0 (no writeback)
    issue(OP_LOAD, 3'b001, 32'h1002, 32'd0, 5'd7, 1'b1, 32'h10C);
    push(OP_LOAD, 32'h1002, 32'hFFFF_80AA, 5'd7, 1'b1, 32'h10C, 1'b0);
    mem_access(1, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80AA_BBCC);
    issue(OP_LOAD, 3'b101, 32'h1000, 32'd0, 5'd8, 1'b1, 32'h110);
    push(OP_LOAD, 32'h1000, 32'h0000_BBCC, 5'd8, 1'b1, 32'h110, 1'b0);
    mem_access(2, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80AA_BBCC);
    issue(OP_LOAD, 3'b010, 32'h1004, 32'd0, 5'd0, 1'b1, 32'h114);
    push(OP_LOAD, 32'h1004, 32'h80AA_BBCC, 5'd0, 1'b0, 32'h114, 1'b0);
    mem_access(1, 32'h1004, 1'b0, 4'b0000, 32'd0, 32'h80AA_BBCC);

    // Stores: SH upper, SB lane 1, SW
    issue(OP_STORE, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd9, 1'b1, 32'h118);
    push(OP_STORE, 32'h2002, 32'd0, 5'd9, 1'b0, 32'h118, 1'b0);
    mem_access(2, 32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD, JUNK);
    issue(OP_STORE, 3'b000, 32'h2001, 32'h0000_0077, 5'd1, 1'b0, 32'h11C);
    push(OP_STORE, 32'h2001, 32'd0, 5'd1, 1'b0, 32'h11C, 1'b0);
    mem_access(1, 32'h2000, 1'b1, 4'b0010, 32'h7777_7777, JUNK);
    issue(OP_STORE, 3'b010, 32'h2004, 32'hCAFE_F00D, 5'd2, 1'b0, 32'h120);
    push(OP_STORE, 32'h2004, 32'd0, 5'd2, 1'b0, 32'h120, 1'b0);
    mem_access(1, 32'h2004, 1'b1, 4'b1111, 32'hCAFE_F00D, JUNK);

    // Faults: misaligned LW, misaligned LH, illegal store funct3, illegal load funct3
    fault_op(OP_LOAD,  3'b010, 32'h3001, 5'd4, 32'h124);
    fault_op(OP_LOAD,  3'b001, 32'h3003, 5'd4, 32'h128);
    fault_op(OP_STORE, 3'b011, 32'h3000, 5'd0, 32'h12C);
    fault_op(OP_LOAD,  3'b110, 32'h3000, 5'd4, 32'h130);

    // Stray ack while IDLE must not retire anything
    @(posedge clk); #1;
    i_dmem_ack = 1'b1;
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_valid", 32'(o_valid), 32'd0);

    // Back-to-back ADD, LW (k=1), ADD: o_valid in cycles 1,3,4; stall in 2
    @(posedge clk); #1;
    drive(OP_REG, 3'b000, 32'h0000_00AA, 32'd0, 5'd10, 1'b1, 32'h200);
    push(OP_REG, 32'hAA, 32'd0, 5'd10, 1'b1, 32'h200, 1'b0);
    @(negedge clk);
    chk("b2b_c0_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    drive(OP_LOAD, 3'b010, 32'h5000, 32'd0, 5'd11, 1'b1, 32'h204);
    push(OP_LOAD, 32'h5000, 32'h1122_3344, 5'd11, 1'b1, 32'h204, 1'b0);
    @(negedge clk);
    chk("b2b_c1_valid", 32'(o_valid), 32'd1);
    chk("b2b_c1_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    drive(OP_REG, 3'b000, 32'h0000_00BB, 32'd0, 5'd12, 1'b1, 32'h208);
    push(OP_REG, 32'hBB, 32'd0, 5'd12, 1'b1, 32'h208, 1'b0);
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("b2b_c2_valid", 32'(o_valid),    32'd0);
    chk("b2b_c2_ready", 32'(o_ready),    32'd0);
    chk("b2b_c2_req",   32'(o_dmem_req), 32'd1);
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = JUNK;
    @(negedge clk);
    chk("b2b_c3_valid", 32'(o_valid), 32'd1);
    chk("b2b_c3_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    chk("b2b_c4_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_c5_valid", 32'(o_valid), 32'd0);

    // Reset during ACCESS, then a late ack
    issue(OP_LOAD, 3'b010, 32'h4000, 32'd0, 5'd13, 1'b1, 32'h300);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    chk("rst_mid_req_before", 32'(o_dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rst_mid_req",   32'(o_dmem_req), 32'd0);
    chk("rst_mid_ready", 32'(o_ready),    32'd1);
    chk("rst_mid_valid", 32'(o_valid),    32'd0);
    chk("rst_mid_addr",  o_dmem_addr,     32'd0);
    chk("rst_mid_alu",   o_alu_result,    32'd0);
    chk("rst_mid_pc",    o_pc,            32'd0);
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = JUNK;
    @(negedge clk);
    chk("late_ack_valid", 32'(o_valid),    32'd0);
    chk("late_ack_req",   32'(o_dmem_req), 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
